// File: rtl/game_mem_pkg.sv
// Shared types and default addresses for the game-state memory arbiter and its poller.
package game_mem_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      CPU_BUSY  = 2'd1,
      POLL_BUSY = 2'd2
   } arb_state_t;

   typedef enum logic [1:0] {
      POLL_P1 = 2'd0,
      POLL_P2 = 2'd1,
      POLL_D1 = 2'd2,
      POLL_D2 = 2'd3
   } poll_idx_t;

   typedef logic [1:0] lives_t;
   typedef logic [1:0] door_t;

   localparam logic [31:0] DEF_ADDR_P1_LIVES = 32'h0000_6000;
   localparam logic [31:0] DEF_ADDR_P2_LIVES = 32'h0000_7000;
   localparam logic [31:0] DEF_ADDR_DOOR_1   = 32'h0000_3000;
   localparam logic [31:0] DEF_ADDR_DOOR_2   = 32'h0000_4000;
   localparam int unsigned DEF_STARVE_MAX    = 8;

   function automatic poll_idx_t next_poll_idx(input poll_idx_t idx);
      return poll_idx_t'(idx + 2'd1);
   endfunction

endpackage

// File: rtl/game_state_poller.sv
// Background poller: poll index, starvation counter, poll address select and shadow capture.
// Build option GAME_MEM_SNOOP_EN lets acknowledged CPU writes update the shadows directly.
module game_state_poller
   import game_mem_pkg::*;
#(
   parameter logic [31:0] ADDR_P1_LIVES = DEF_ADDR_P1_LIVES,
   parameter logic [31:0] ADDR_P2_LIVES = DEF_ADDR_P2_LIVES,
   parameter logic [31:0] ADDR_DOOR_1   = DEF_ADDR_DOOR_1,
   parameter logic [31:0] ADDR_DOOR_2   = DEF_ADDR_DOOR_2,
   parameter int unsigned STARVE_MAX    = DEF_STARVE_MAX
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        poll_en,
   input  logic        poll_grant,
   input  logic        capture,
   input  logic [1:0]  mem_rd_lo,
   input  logic        snoop_wr,
   input  logic [31:0] snoop_addr,
   input  logic [1:0]  snoop_data,
   output logic [31:0] poll_addr,
   output logic        starved,
   output lives_t      p1_lives,
   output lives_t      p2_lives,
   output door_t       door_1,
   output door_t       door_2,
   output logic        state_valid,
   output logic        refresh_done
);

   localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

   poll_idx_t  idx;
   poll_idx_t  cap_idx;
   logic [7:0] starve_cnt;

   always_comb begin
      poll_addr = ADDR_P1_LIVES;
      unique case (idx)
         POLL_P1: poll_addr = ADDR_P1_LIVES;
         POLL_P2: poll_addr = ADDR_P2_LIVES;
         POLL_D1: poll_addr = ADDR_DOOR_1;
         POLL_D2: poll_addr = ADDR_DOOR_2;
      endcase
   end

   assign starved = (starve_cnt == STARVE_LIM);

`ifndef GAME_MEM_SNOOP_EN
   logic unused_snoop;
   assign unused_snoop = ^{snoop_wr, snoop_addr, snoop_data};
`endif

   // idx advances at issue so a back-to-back poll targets the next word;
   // cap_idx remembers which shadow the in-flight read belongs to.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idx          <= POLL_P1;
         cap_idx      <= POLL_P1;
         starve_cnt   <= '0;
         p1_lives     <= 2'b11;
         p2_lives     <= 2'b11;
         door_1       <= 2'b00;
         door_2       <= 2'b00;
         state_valid  <= 1'b0;
         refresh_done <= 1'b0;
      end else begin
         refresh_done <= 1'b0;
         if (poll_grant) begin
            cap_idx <= idx;
            idx     <= next_poll_idx(idx);
         end
         if (!poll_en || poll_grant)
            starve_cnt <= '0;
         else if (starve_cnt != STARVE_LIM)
            starve_cnt <= starve_cnt + 8'd1;
         if (capture) begin
            unique case (cap_idx)
               POLL_P1: p1_lives <= mem_rd_lo;
               POLL_P2: p2_lives <= mem_rd_lo;
               POLL_D1: door_1   <= mem_rd_lo;
               POLL_D2: begin
                  door_2       <= mem_rd_lo;
                  refresh_done <= 1'b1;
                  state_valid  <= 1'b1;
               end
            endcase
         end
`ifdef GAME_MEM_SNOOP_EN
         // Never coincides with a poll capture: CPU and poll completions are exclusive.
         if (snoop_wr) begin
            if (snoop_addr == ADDR_P1_LIVES) p1_lives <= snoop_data;
            if (snoop_addr == ADDR_P2_LIVES) p2_lives <= snoop_data;
            if (snoop_addr == ADDR_DOOR_1)   door_1   <= snoop_data;
            if (snoop_addr == ADDR_DOOR_2)   door_2   <= snoop_data;
         end
`endif
      end
   end

endmodule

// File: rtl/game_mem_arbiter.sv
// Shares the DataMemory port between the CPU (priority) and the game-state poller.
// Optional GAME_MEM_SNOOP_EN: acknowledged CPU writes to polled addresses update shadows at once.
module game_mem_arbiter
   import game_mem_pkg::*;
#(
   parameter logic [31:0] ADDR_P1_LIVES = DEF_ADDR_P1_LIVES,
   parameter logic [31:0] ADDR_P2_LIVES = DEF_ADDR_P2_LIVES,
   parameter logic [31:0] ADDR_DOOR_1   = DEF_ADDR_DOOR_1,
   parameter logic [31:0] ADDR_DOOR_2   = DEF_ADDR_DOOR_2,
   parameter int unsigned STARVE_MAX    = DEF_STARVE_MAX
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_ack,
   output logic [31:0] mem_a,
   output logic [31:0] mem_wd,
   output logic        mem_we,
   input  logic [31:0] mem_rd,
   input  logic        poll_en,
   output lives_t      p1_lives,
   output lives_t      p2_lives,
   output door_t       door_1,
   output door_t       door_2,
   output logic        state_valid,
   output logic        refresh_done
);

   arb_state_t  state;
   arb_state_t  state_nx;
   logic        cpu_elig;
   logic        cpu_grant;
   logic        poll_grant;
   logic        starved;
   logic [31:0] poll_addr;
   logic [31:0] mem_a_q;
   logic [31:0] mem_wd_q;
   logic        we_q;

   // Grants are gated by reset_n so the memory port shows reset values immediately.
   always_comb begin
      cpu_elig   = cpu_req && (state != CPU_BUSY);
      poll_grant = reset_n && poll_en && (starved || !cpu_elig);
      cpu_grant  = reset_n && cpu_elig && !poll_grant;
      state_nx   = IDLE;
      mem_a      = mem_a_q;
      mem_wd     = mem_wd_q;
      mem_we     = 1'b0;
      if (cpu_grant) begin
         state_nx = CPU_BUSY;
         mem_a    = cpu_addr;
         mem_wd   = cpu_wdata;
         mem_we   = cpu_we;
      end else if (poll_grant) begin
         state_nx = POLL_BUSY;
         mem_a    = poll_addr;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         mem_a_q  <= '0;
         mem_wd_q <= '0;
         we_q     <= 1'b0;
      end else begin
         state    <= state_nx;
         mem_a_q  <= mem_a;
         mem_wd_q <= mem_wd;
         if (cpu_grant)
            we_q <= cpu_we;
      end
   end

   assign cpu_ack   = (state == CPU_BUSY);
   assign cpu_rdata = (cpu_ack && !we_q) ? mem_rd : '0;

   game_state_poller #(
      .ADDR_P1_LIVES (ADDR_P1_LIVES),
      .ADDR_P2_LIVES (ADDR_P2_LIVES),
      .ADDR_DOOR_1   (ADDR_DOOR_1),
      .ADDR_DOOR_2   (ADDR_DOOR_2),
      .STARVE_MAX    (STARVE_MAX)
   ) u_poller (
      .clk          (clk),
      .reset_n      (reset_n),
      .poll_en      (poll_en),
      .poll_grant   (poll_grant),
      .capture      (state == POLL_BUSY),
      .mem_rd_lo    (mem_rd[1:0]),
      .snoop_wr     (cpu_ack && we_q),
      .snoop_addr   (mem_a_q),
      .snoop_data   (mem_wd_q[1:0]),
      .poll_addr    (poll_addr),
      .starved      (starved),
      .p1_lives     (p1_lives),
      .p2_lives     (p2_lives),
      .door_1       (door_1),
      .door_2       (door_2),
      .state_valid  (state_valid),
      .refresh_done (refresh_done)
   );

endmodule

// File: tb/tb_game_mem_arbiter.sv
// Randomized bench for game_mem_arbiter against a transaction-level reference model.
`timescale 1ns/1ps
module tb_game_mem_arbiter;

   localparam int          STARVE_MAX = 8;
   localparam logic [31:0] A_P1 = 32'h0000_6000;
   localparam logic [31:0] A_P2 = 32'h0000_7000;
   localparam logic [31:0] A_D1 = 32'h0000_3000;
   localparam logic [31:0] A_D2 = 32'h0000_4000;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cpu_req, cpu_we, mem_we, cpu_ack, poll_en, state_valid, refresh_done;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, mem_a, mem_wd, mem_rd;
   logic [1:0]  p1_lives, p2_lives, door_1, door_2;

   always #5 clk = ~clk;

   game_mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .reset_n(reset_n), .cpu_req(cpu_req), .cpu_we(cpu_we),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
      .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd), .poll_en(poll_en),
      .p1_lives(p1_lives), .p2_lives(p2_lives), .door_1(door_1), .door_2(door_2),
      .state_valid(state_valid), .refresh_done(refresh_done)
   );

   // Address set used by the bench; slots 0..3 are the polled words in poll order.
   logic [31:0] addr_tab [8] = '{32'h6000, 32'h7000, 32'h3000, 32'h4000,
                                 32'h1000, 32'h2000, 32'h5000, 32'h8000};

   function automatic int slot_of(input logic [31:0] a);
      for (int k = 0; k < 7; k++) if (a == addr_tab[k]) return k;
      return 7;
   endfunction

   function automatic logic [31:0] preload(input int k);
      case (k)
         0: return 32'd2;
         1: return 32'd1;
         2: return 32'd3;
         default: return 32'd0;
      endcase
   endfunction

   // Environment memory: one-cycle read latency, reloaded while reset is held.
   logic [31:0] env_mem [8];
   always @(posedge clk) begin
      if (!reset_n) begin
         for (int k = 0; k < 8; k++) env_mem[k] <= preload(k);
         mem_rd <= '0;
      end else begin
         mem_rd <= env_mem[slot_of(mem_a)];
         if (mem_we) env_mem[slot_of(mem_a)] <= mem_wd;
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: what is in flight, the poll order, shadows and predicted memory.
   int          m_busy;      // 0 nothing, 1 CPU access, 2 poll read
   int          m_pidx, m_pend_idx, m_starve;
   logic        m_pend_we, m_valid, m_done, m_ack_last;
   logic [31:0] m_pend_addr, m_pend_wd, m_pend_rd, m_ahold, m_wdhold;
   logic [1:0]  m_sh [4];
   logic [31:0] m_mem [8];

   logic        want_req, want_we, want_poll;
   logic [31:0] want_addr, want_data;
   int          n_req, n_dack, n_we, n_ref;
   logic        last_ack;
   logic [31:0] last_rd;

   task automatic model_reset();
      m_busy = 0; m_pidx = 0; m_pend_idx = 0; m_starve = 0;
      m_pend_we = 0; m_valid = 0; m_done = 0; m_ack_last = 0;
      m_pend_addr = '0; m_pend_wd = '0; m_pend_rd = '0; m_ahold = '0; m_wdhold = '0;
      m_sh[0] = 2'b11; m_sh[1] = 2'b11; m_sh[2] = 2'b00; m_sh[3] = 2'b00;
      for (int k = 0; k < 8; k++) m_mem[k] = preload(k);
   endtask

   task automatic step();
      logic        cpu_ok, pw, cw, eack, ewe;
      logic [31:0] ea, ewd, erd;
      @(negedge clk);
      if (!(cpu_req && !m_ack_last)) begin
         cpu_req = want_req;
         if (want_req) begin
            cpu_we = want_we; cpu_addr = want_addr; cpu_wdata = want_data;
            n_req++;
         end
      end
      poll_en = want_poll;
      #1;
      cpu_ok = cpu_req && (m_busy != 1);
      pw     = poll_en && ((m_starve == STARVE_MAX) || !cpu_ok);
      cw     = cpu_ok && !pw;
      ea     = cw ? cpu_addr : (pw ? addr_tab[m_pidx] : m_ahold);
      ewd    = cw ? cpu_wdata : m_wdhold;
      ewe    = cw && cpu_we;
      eack   = (m_busy == 1);
      erd    = (eack && !m_pend_we) ? m_pend_rd : '0;
      chk("mem_a", mem_a, ea);
      chk("mem_we", {31'b0, mem_we}, {31'b0, ewe});
      chk("mem_wd", mem_wd, ewd);
      chk("cpu_ack", {31'b0, cpu_ack}, {31'b0, eack});
      chk("cpu_rdata", cpu_rdata, erd);
      chk("p1_lives", {30'b0, p1_lives}, {30'b0, m_sh[0]});
      chk("p2_lives", {30'b0, p2_lives}, {30'b0, m_sh[1]});
      chk("door_1", {30'b0, door_1}, {30'b0, m_sh[2]});
      chk("door_2", {30'b0, door_2}, {30'b0, m_sh[3]});
      chk("state_valid", {31'b0, state_valid}, {31'b0, m_valid});
      chk("refresh_done", {31'b0, refresh_done}, {31'b0, m_done});
      last_ack = cpu_ack; last_rd = cpu_rdata;
      if (cpu_ack === 1'b1) n_dack++;
      if (mem_we === 1'b1) n_we++;
      if (refresh_done === 1'b1) n_ref++;
      // advance the model by one cycle
      m_done = 0;
      if (m_busy == 2) begin
         m_sh[m_pend_idx] = m_pend_rd[1:0];
         if (m_pend_idx == 3) begin m_done = 1; m_valid = 1; end
      end
`ifdef GAME_MEM_SNOOP_EN
      if (m_busy == 1 && m_pend_we)
         for (int k = 0; k < 4; k++) if (m_pend_addr == addr_tab[k]) m_sh[k] = m_pend_wd[1:0];
`endif
      if (!poll_en || pw) m_starve = 0;
      else if (m_starve < STARVE_MAX) m_starve++;
      if (cw) begin
         m_busy = 1; m_pend_we = cpu_we; m_pend_addr = cpu_addr; m_pend_wd = cpu_wdata;
         m_pend_rd = m_mem[slot_of(cpu_addr)];
         if (cpu_we) m_mem[slot_of(cpu_addr)] = cpu_wdata;
      end else if (pw) begin
         m_busy = 2; m_pend_idx = m_pidx; m_pend_rd = m_mem[m_pidx];
         m_pidx = (m_pidx + 1) % 4;
      end else begin
         m_busy = 0;
      end
      m_ahold = ea; m_wdhold = ewd; m_ack_last = eack;
   endtask

   task automatic cpu_do(input logic w, input logic [31:0] a, input logic [31:0] d,
                         output int lat);
      want_req = 1; want_we = w; want_addr = a; want_data = d;
      step();
      want_req = 0;
      lat = 0;
      do begin
         step();
         lat++;
      end while (last_ack !== 1'b1 && lat < 20);
      chk("ack_seen", {31'b0, last_ack}, 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish at %0t", $time);
      $fatal(1);
   end

   initial begin
      int          lat;
      logic [31:0] held;
      int          waitc;
      reset_n = 0; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; poll_en = 0;
      want_req = 0; want_we = 0; want_poll = 0; want_addr = '0; want_data = '0;
      n_req = 0; n_dack = 0; n_we = 0; n_ref = 0; last_ack = 0; last_rd = '0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_ack", {31'b0, cpu_ack}, 32'd0);
      chk("rst_mem_a", mem_a, 32'd0);
      chk("rst_p1", {30'b0, p1_lives}, 32'd3);
      chk("rst_d2", {30'b0, door_2}, 32'd0);
      reset_n = 1;

      // Polling only: one full refresh round from the preloaded memory.
      want_poll = 1;
      repeat (8) step();
      chk("t1_p1", {30'b0, p1_lives}, 32'd2);
      chk("t1_p2", {30'b0, p2_lives}, 32'd1);
      chk("t1_d1", {30'b0, door_1}, 32'd3);
      chk("t1_d2", {30'b0, door_2}, 32'd0);
      chk("t1_refresh_cnt", n_ref, 32'd1);
      chk("t1_valid", {31'b0, state_valid}, 32'd1);

      // CPU write then read with the poller off.
      want_poll = 0;
      n_we = 0;
      cpu_do(1'b1, A_D1, 32'd2, lat);
      chk("wr_latency", lat, 32'd1);
      chk("wr_we_cycles", n_we, 32'd1);
      cpu_do(1'b0, A_D1, 32'd0, lat);
      chk("rd_latency", lat, 32'd1);
      chk("rd_data", last_rd, 32'd2);

      // Drop poll_en right after the D1 read issues.
      want_poll = 1;
      waitc = 0;
      do begin step(); waitc++; end while (!(m_busy == 2 && m_pend_idx == 2) && waitc < 20);
      chk("d1_issued", mem_a, A_D1);
      want_poll = 0;
      step();
      step();
      chk("d1_captured", {30'b0, door_1}, 32'd2);
      held = mem_a;
      repeat (4) step();
      chk("addr_held", mem_a, held);
      want_poll = 1;
      step();
      chk("resume_d2", mem_a, A_D2);

      // Shadow of P1 versus a CPU write to its address.
      want_poll = 0;
      cpu_do(1'b1, A_P1, 32'd3, lat);
      want_poll = 1;
      repeat (6) step();
      want_poll = 0;
      repeat (2) step();
      chk("snoop_pre", {30'b0, p1_lives}, 32'd3);
      cpu_do(1'b1, A_P1, 32'd1, lat);
      step();
`ifdef GAME_MEM_SNOOP_EN
      chk("snoop_p1", {30'b0, p1_lives}, 32'd1);
`else
      chk("snoop_p1", {30'b0, p1_lives}, 32'd3);
`endif
      want_poll = 1;
      repeat (6) step();
      chk("polled_p1", {30'b0, p1_lives}, 32'd1);

      // Randomized traffic.
      for (int i = 0; i < 1500; i++) begin
         want_req  = ($urandom_range(0, 3) != 0);
         want_we   = $urandom_range(0, 1) == 1;
         want_addr = addr_tab[$urandom_range(0, 7)];
         want_data = $urandom;
         want_poll = ($urandom_range(0, 7) != 0);
         step();
      end

      // Continuous CPU demand with polling enabled, then drain.
      want_poll = 1;
      want_req  = 1;
      for (int i = 0; i < 60; i++) begin
         want_we = $urandom_range(0, 1) == 1; want_addr = addr_tab[$urandom_range(0, 7)];
         want_data = $urandom;
         step();
      end
      want_req = 0;
      repeat (6) step();
      chk("no_loss", n_dack, n_req);

      // Reset while a CPU read is in flight.
      want_poll = 0;
      repeat (2) step();
      want_req = 1; want_we = 0; want_addr = A_P2;
      step();
      want_req = 0;
      @(posedge clk);
      #2;
      reset_n = 0;
      cpu_req = 0;
      #1;
      chk("ar_ack", {31'b0, cpu_ack}, 32'd0);
      chk("ar_rdata", cpu_rdata, 32'd0);
      chk("ar_mem_we", {31'b0, mem_we}, 32'd0);
      chk("ar_mem_a", mem_a, 32'd0);
      chk("ar_mem_wd", mem_wd, 32'd0);
      chk("ar_p2", {30'b0, p2_lives}, 32'd3);
      chk("ar_d1", {30'b0, door_1}, 32'd0);
      chk("ar_valid", {31'b0, state_valid}, 32'd0);
      chk("ar_refresh", {31'b0, refresh_done}, 32'd0);
      model_reset();
      repeat (2) @(negedge clk);
      reset_n = 1;
      want_poll = 1;
      step();
      chk("resume_p1", mem_a, A_P1);
      repeat (8) step();
      chk("post_rst_p1", {30'b0, p1_lives}, 32'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
